ucsbece154a_rfwarb: RTL and testbench

Write-port arbiter and pending-register scoreboard for the single-write-port register file. Two writeback sources share the one write port: the pipeline writeback stage (P) and a multi-cycle execution unit (M, e.g. mul/div). The block also tracks destination registers with an outstanding M operation, so the hazard unit can stall dependent instructions. It sits between the writeback sources and the register file's we3/a3/wd3 inputs.

---
 rtl/ucsbece154a_rfwarb.sv | 125 ++++++++++++
 tb/tb_ucsbece154a_rfwarb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_rfwarb.sv
// Register-file write-port arbiter (pipeline vs multi-cycle unit) with pending-M scoreboard.
// Optional forwarding from the write register: define UCSBECE154A_RFARB_FWD_EN.
module ucsbece154a_rfwarb #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_valid_i,
    input  logic [4:0]  p_a_i,
    input  logic [31:0] p_wd_i,
    output logic        p_ready_o,
    input  logic        m_valid_i,
    input  logic [4:0]  m_a_i,
    input  logic [31:0] m_wd_i,
    output logic        m_ready_o,
    input  logic        iss_valid_i,
    input  logic [4:0]  iss_a_i,
    input  logic [4:0]  chk_a1_i,
    input  logic [4:0]  chk_a2_i,
    output logic        hazard_o,
    output logic        fwd1_o,
    output logic        fwd2_o,
    output logic        we3_o,
    output logic [4:0]  a3_o,
    output logic [31:0] wd3_o
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]  starve_q, starve_d;
    logic [31:1] pending_q, pending_d;
    logic        m_inflight_q, m_inflight_d;
    logic        we3_q, we3_d;
    logic [4:0]  a3_q, a3_d;
    logic [31:0] wd3_q, wd3_d;
    logic        force_m;
    logic [31:0] pend_w;

    assign pend_w = {pending_q, 1'b0};

    always_comb begin
        force_m   = m_valid_i & (starve_q == SMAX);
        p_ready_o = p_valid_i & ~force_m;
        m_ready_o = m_valid_i & (force_m | ~p_valid_i);
    end

    always_comb begin
        starve_d     = starve_q;
        we3_d        = 1'b0;
        a3_d         = a3_q;
        wd3_d        = wd3_q;
        m_inflight_d = 1'b0;
        if (!m_valid_i || m_ready_o) begin
            starve_d = 4'd0;
        end else if (starve_q != SMAX) begin
            starve_d = starve_q + 4'd1;
        end
        if (p_ready_o) begin
            we3_d = (p_a_i != 5'd0);
            a3_d  = p_a_i;
            wd3_d = p_wd_i;
        end else if (m_ready_o) begin
            we3_d        = (m_a_i != 5'd0);
            a3_d         = m_a_i;
            wd3_d        = m_wd_i;
            m_inflight_d = (m_a_i != 5'd0);
        end
    end

    // Retire clears first so a same-edge issue to that register wins.
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < 32; i++) begin
            if (m_inflight_q && we3_q && a3_q == 5'(i)) begin
                pending_d[i] = 1'b0;
            end
            if (iss_valid_i && iss_a_i == 5'(i)) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q     <= 4'd0;
            pending_q    <= '0;
            m_inflight_q <= 1'b0;
            we3_q        <= 1'b0;
            a3_q         <= 5'd0;
            wd3_q        <= 32'd0;
        end else begin
            starve_q     <= starve_d;
            pending_q    <= pending_d;
            m_inflight_q <= m_inflight_d;
            we3_q        <= we3_d;
            a3_q         <= a3_d;
            wd3_q        <= wd3_d;
        end
    end

`ifdef UCSBECE154A_RFARB_FWD_EN
    always_comb begin
        fwd1_o = m_inflight_q & we3_q & (a3_q == chk_a1_i) & (chk_a1_i != 5'd0);
        fwd2_o = m_inflight_q & we3_q & (a3_q == chk_a2_i) & (chk_a2_i != 5'd0);
    end
`else
    assign fwd1_o = 1'b0;
    assign fwd2_o = 1'b0;
`endif

    assign hazard_o = (pend_w[chk_a1_i] & ~fwd1_o) | (pend_w[chk_a2_i] & ~fwd2_o);

    assign we3_o = we3_q;
    assign a3_o  = a3_q;
    assign wd3_o = wd3_q;

`ifdef SIM
    always @(posedge clk) begin
        if (!reset && iss_valid_i && iss_a_i != 5'd0 && pend_w[iss_a_i]) begin
            $warning("rfwarb: issue to already-pending x%0d", iss_a_i);
        end
    end
`endif

endmodule

// File: tb/tb_ucsbece154a_rfwarb.sv
// Bench for ucsbece154a_rfwarb: per-cycle reference model plus directed literal checks.
module tb_ucsbece154a_rfwarb;

    localparam int SM = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid_i, m_valid_i, iss_valid_i;
    logic [4:0]  p_a_i, m_a_i, iss_a_i, chk_a1_i, chk_a2_i;
    logic [31:0] p_wd_i, m_wd_i;
    logic        p_ready_o, m_ready_o, hazard_o, fwd1_o, fwd2_o, we3_o;
    logic [4:0]  a3_o;
    logic [31:0] wd3_o;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;
    bit written[32];

    ucsbece154a_rfwarb #(.STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .p_valid_i(p_valid_i), .p_a_i(p_a_i), .p_wd_i(p_wd_i), .p_ready_o(p_ready_o),
        .m_valid_i(m_valid_i), .m_a_i(m_a_i), .m_wd_i(m_wd_i), .m_ready_o(m_ready_o),
        .iss_valid_i(iss_valid_i), .iss_a_i(iss_a_i),
        .chk_a1_i(chk_a1_i), .chk_a2_i(chk_a2_i),
        .hazard_o(hazard_o), .fwd1_o(fwd1_o), .fwd2_o(fwd2_o),
        .we3_o(we3_o), .a3_o(a3_o), .wd3_o(wd3_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state as seen just after the most recent edge.
    bit          mpend[32];
    int          mstarve = 0;
    bit          mwe = 0;
    bit          minfl = 0;
    logic [4:0]  ma3 = 0;
    logic [31:0] mwd = 0;

    always @(negedge clk) begin
        bit frc, epr, emr, ef1, ef2, ehz;
        frc = m_valid_i && (mstarve == SM);
        epr = p_valid_i && !frc;
        emr = m_valid_i && !epr;
        ef1 = 0;
        ef2 = 0;
`ifdef UCSBECE154A_RFARB_FWD_EN
        ef1 = minfl && mwe && ma3 == chk_a1_i && chk_a1_i != 0;
        ef2 = minfl && mwe && ma3 == chk_a2_i && chk_a2_i != 0;
`endif
        ehz = (chk_a1_i != 0 && mpend[chk_a1_i] && !ef1) ||
              (chk_a2_i != 0 && mpend[chk_a2_i] && !ef2);
        if (chk_en) begin
            chk("p_ready", 32'(p_ready_o), 32'(epr));
            chk("m_ready", 32'(m_ready_o), 32'(emr));
            chk("hazard", 32'(hazard_o), 32'(ehz));
            chk("fwd1", 32'(fwd1_o), 32'(ef1));
            chk("fwd2", 32'(fwd2_o), 32'(ef2));
            chk("we3", 32'(we3_o), 32'(mwe));
            chk("a3", 32'(a3_o), 32'(ma3));
            chk("wd3", wd3_o, mwd);
            if (we3_o === 1'b1 && !reset) written[a3_o] = 1;
        end
        if (reset) begin
            foreach (mpend[i]) mpend[i] = 0;
            mstarve = 0; mwe = 0; minfl = 0; ma3 = 0; mwd = 0;
        end else begin
            if (minfl && mwe) mpend[ma3] = 0;
            if (iss_valid_i && iss_a_i != 0) mpend[iss_a_i] = 1;
            if (!m_valid_i || emr) mstarve = 0;
            else if (mstarve < SM) mstarve++;
            mwe = 0;
            minfl = 0;
            if (epr) begin
                mwe = p_a_i != 0; ma3 = p_a_i; mwd = p_wd_i;
            end else if (emr) begin
                mwe = m_a_i != 0; ma3 = m_a_i; mwd = m_wd_i; minfl = m_a_i != 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid_i = 0; p_a_i = 0; p_wd_i = 0;
        m_valid_i = 0; m_a_i = 0; m_wd_i = 0;
        iss_valid_i = 0; iss_a_i = 0;
        chk_a1_i = 0; chk_a2_i = 0;
    endtask

    task automatic setp(input logic v, input logic [4:0] a, input logic [31:0] d);
        p_valid_i = v; p_a_i = a; p_wd_i = d;
    endtask

    task automatic setm(input logic v, input logic [4:0] a, input logic [31:0] d);
        m_valid_i = v; m_a_i = a; m_wd_i = d;
    endtask

    initial begin
        reset = 1;
        idle();
        @(posedge clk);
        #1 chk_en = 1;
        cyc();
        reset = 0;
        #2;
        chk("rst we3", 32'(we3_o), 0);
        chk("rst a3", 32'(a3_o), 0);
        chk("rst wd3", wd3_o, 0);
        chk("rst hazard", 32'(hazard_o), 0);

        // Priority: P wins a simultaneous request.
        cyc();
        setp(1, 3, 32'h11); setm(1, 4, 32'h22);
        #2;
        chk("prio p_ready", 32'(p_ready_o), 1);
        chk("prio m_ready", 32'(m_ready_o), 0);
        cyc();
        setp(0, 0, 0);
        #2;
        chk("prio we3", 32'(we3_o), 1);
        chk("prio a3", 32'(a3_o), 3);
        chk("prio wd3", wd3_o, 32'h11);
        chk("prio m_ready late", 32'(m_ready_o), 1);
        cyc();
        setm(0, 0, 0);
        #2;
        chk("m write a3", 32'(a3_o), 4);
        chk("m write wd3", wd3_o, 32'h22);

        // Starvation: M force-granted in the fourth contended cycle.
        for (int c = 0; c < 4; c++) begin
            cyc();
            setp(1, 5'(10 + c), 32'h100 + 32'(c)); setm(1, 12, 32'hABC);
            #2;
            chk("starve m_ready", 32'(m_ready_o), (c == SM) ? 1 : 0);
            chk("starve p_ready", 32'(p_ready_o), (c == SM) ? 0 : 1);
        end
        cyc();
        setm(0, 0, 0);
        #2;
        chk("starve m a3", 32'(a3_o), 12);
        chk("starve m wd3", wd3_o, 32'hABC);
        cyc();
        setm(1, 13, 32'h77);
        #2;
        chk("starve cleared", 32'(m_ready_o), 0);
        cyc();
        setp(0, 0, 0);
        cyc();
        idle();

        // x0 write accepted but never enables the port.
        cyc();
        setp(1, 0, 32'hDEAD);
        #2;
        chk("x0 p_ready", 32'(p_ready_o), 1);
        cyc();
        idle();
        #2;
        chk("x0 we3", 32'(we3_o), 0);

        // Scoreboard: issue x7 in cycle 0, M writes it in cycle 5.
        cyc();
        iss_valid_i = 1; iss_a_i = 7; chk_a1_i = 7;
        #2;
        chk("sb c0 hazard", 32'(hazard_o), 0);
        for (int c = 1; c < 5; c++) begin
            cyc();
            iss_valid_i = 0; chk_a2_i = (c == 3) ? 5'd7 : 5'd0;
            #2;
            chk("sb pending hazard", 32'(hazard_o), 1);
        end
        cyc();
        chk_a2_i = 0;
        setm(1, 7, 32'h55);
        #2;
        chk("sb m_ready", 32'(m_ready_o), 1);
        cyc();
        setm(0, 0, 0);
        chk_a2_i = 7;
        #2;
        chk("sb c6 we3", 32'(we3_o), 1);
        chk("sb c6 wd3", wd3_o, 32'h55);
`ifdef UCSBECE154A_RFARB_FWD_EN
        chk("sb c6 fwd1", 32'(fwd1_o), 1);
        chk("sb c6 hazard", 32'(hazard_o), 0);
`else
        chk("sb c6 hazard", 32'(hazard_o), 1);
`endif
        cyc();
        #2;
        chk("sb c7 hazard", 32'(hazard_o), 0);
        cyc();
        idle();

        // Set wins over same-edge retire on x9.
        cyc();
        iss_valid_i = 1; iss_a_i = 9; chk_a1_i = 9;
        cyc();
        iss_valid_i = 0;
        cyc();
        setm(1, 9, 32'h99);
        cyc();
        setm(0, 0, 0);
        iss_valid_i = 1; iss_a_i = 9;
        cyc();
        iss_valid_i = 0;
        #2;
        chk("setwins hazard", 32'(hazard_o), 1);
        cyc();
        idle();

        // Reset while an M write of x5 is transferring.
        cyc();
        iss_valid_i = 1; iss_a_i = 5;
        cyc();
        iss_valid_i = 0;
        cyc();
        setm(1, 5, 32'h5555);
        reset = 1;
        cyc();
        reset = 0;
        setm(0, 0, 0);
        chk_a1_i = 5;
        #2;
        chk("rstmid we3", 32'(we3_o), 0);
        chk("rstmid hazard", 32'(hazard_o), 0);
        cyc();
        cyc();
        idle();
        chk("rstmid x5 written", 32'(written[5]), 0);
        chk("x7 written", 32'(written[7]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
